// File: rtl/principal_top.sv
// LED pattern generator: prescaler tick drives an 8-bit up-count, optionally followed by a bouncing scan.
// Optional scan states are built only when PRINCIPAL_SCAN_EN is defined.
module principal_top #(
  parameter int unsigned TICK_DIV = 32'd16_666_667
) (
  input  logic       clk,
  input  logic       nrst,
  output logic [7:0] led
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_COUNT  = 2'b00,
    S_SCAN_L = 2'b01,
    S_SCAN_R = 2'b10
  } state_t;

  logic [CW-1:0] div_cnt;
  logic          tick;
  state_t        state, state_nx;
  logic [7:0]    led_nx;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (nrst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= S_COUNT;
      led   <= 8'h00;
    end else begin
      state <= state_nx;
      led   <= led_nx;
    end
  end

  always_comb begin
    state_nx = state;
    led_nx   = led;
    if (tick) begin
      case (state)
        S_COUNT: begin
          if (led != 8'hFF) begin
            led_nx = led + 8'd1;
          end else begin
`ifdef PRINCIPAL_SCAN_EN
            led_nx   = 8'h01;
            state_nx = S_SCAN_L;
`else
            led_nx   = 8'h00;
`endif
          end
        end
`ifdef PRINCIPAL_SCAN_EN
        S_SCAN_L: begin
          if (led != 8'h80) begin
            led_nx = led << 1;
          end else begin
            led_nx   = 8'h40;
            state_nx = S_SCAN_R;
          end
        end
        S_SCAN_R: begin
          if (led != 8'h01) begin
            led_nx = led >> 1;
          end else begin
            led_nx   = 8'h00;
            state_nx = S_COUNT;
          end
        end
`endif
        // Unused encodings recover to a clean count start.
        default: begin
          state_nx = S_COUNT;
          led_nx   = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_principal_top.sv
// Bench for principal_top: three prescaler settings checked every cycle against a tick-count pattern model,
// with a targeted mid-scan reset and random reset pulses.
module tb_principal_top;

  logic       clk;
  logic       r4, r1, r7;
  logic [7:0] led4, led1, led7;

  int unsigned e4, e1, e7;
  int          checks;
  int          failures;

  principal_top #(.TICK_DIV(4)) u_d4 (.clk(clk), .nrst(r4), .led(led4));
  principal_top #(.TICK_DIV(1)) u_d1 (.clk(clk), .nrst(r1), .led(led1));
  principal_top #(.TICK_DIV(7)) u_d7 (.clk(clk), .nrst(r7), .led(led7));

  initial clk = 1'b0;
  always #3 clk = ~clk;

  // Expected LED value after n ticks since reset, from the pattern definition.
  function automatic logic [7:0] pat(input int unsigned n);
    int unsigned k;
    logic [7:0]  one, top;
    one = 8'h01;
    top = 8'h80;
`ifdef PRINCIPAL_SCAN_EN
    k = n % 271;
    if (k < 256)      return 8'(k);
    else if (k < 264) return one << (k - 256);
    else              return top >> (k - 263);
`else
    k = n % 256;
    return 8'(k);
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge: advance each model's edge count (zeroed by reset), then sample.
  task automatic cycle();
    @(posedge clk);
    e4 = r4 ? 0 : e4 + 1;
    e1 = r1 ? 0 : e1 + 1;
    e7 = r7 ? 0 : e7 + 1;
    #1;
    chk($sformatf("div4 e=%0d", e4), led4, pat(e4 / 4));
    chk($sformatf("div1 e=%0d", e1), led1, pat(e1));
    chk($sformatf("div7 e=%0d", e7), led7, pat(e7 / 7));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    e4 = 0; e1 = 0; e7 = 0;
    r4 = 1'b1; r1 = 1'b1; r7 = 1'b1;
    repeat (4) cycle();
    r4 = 1'b0; r1 = 1'b0; r7 = 1'b0;

    // Tick 266 leaves led=10 in the right scan; two edges later div_cnt=2.
    while (e4 < 1066) cycle();
`ifdef PRINCIPAL_SCAN_EN
    chk("div4 mid-scan value", led4, 8'h10);
`else
    chk("div4 pre-reset value", led4, 8'h0A);
`endif
    r4 = 1'b1;
    cycle();
    chk("div4 mid reset", led4, 8'h00);
    r4 = 1'b0;
    repeat (3) cycle();
    chk("div4 hold before tick", led4, 8'h00);
    cycle();
    chk("div4 first tick", led4, 8'h01);

    // Run every DUT past a full period, then pulse resets at random.
    repeat (1100) cycle();
    repeat (20) begin
      int unsigned n;
      n = $urandom_range(1, 350);
      repeat (n) cycle();
      r4 = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 2) == 0);
      r7 = ($urandom_range(0, 2) == 0);
      n = $urandom_range(1, 3);
      repeat (n) cycle();
      r4 = 1'b0; r1 = 1'b0; r7 = 1'b0;
    end
    repeat (50) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
